// File: rtl/row_scan_reader.sv
// Row array with a single write port and a scan engine that streams a
// contiguous, possibly wrapping range of rows over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for scan_start; output register idle
// SCAN  | presenting row ptr; advances on each accepted word
// DONE  | one-cycle done pulse, then back to IDLE
module row_scan_reader #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [0:WIDTH-1] wr_data,
  input  logic             scan_start,
  input  logic [AW-1:0]    scan_first,
  input  logic [AW-1:0]    scan_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_data,
  output logic [AW-1:0]    out_addr,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [0:WIDTH-1] mem [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    first_q, first_d;
  logic [AW-1:0]    last_q, last_d;
  logic [AW-1:0]    load_addr;
  logic             load_en;
  logic [0:WIDTH-1] load_word;
  logic [0:WIDTH-1] out_data_q;
  logic             out_valid_q, out_last_q, busy_q, done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-cycle write to the row being loaded wins over the stored value.
  assign load_word = (wr_en && (wr_addr == load_addr)) ? wr_data : mem[load_addr];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    first_d   = first_q;
    last_d    = last_q;
    load_en   = 1'b0;
    load_addr = ptr_q;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d   = SCAN;
          first_d   = scan_first;
          last_d    = scan_last;
          ptr_d     = scan_first;
          load_en   = 1'b1;
          load_addr = scan_first;
        end
      end
      SCAN: begin
        if (out_ready) begin
          if (ptr_q == last_q) begin
            state_d = DONE;
          end else begin
            ptr_d     = ptr_q + AW'(1);
            load_en   = 1'b1;
            load_addr = ptr_q + AW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      last_q      <= last_d;
      if (load_en) out_data_q <= load_word;
      out_valid_q <= (state_d == SCAN);
      out_last_q  <= (state_d == SCAN) && (ptr_d == last_d);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = ptr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_row_scan_reader.sv
// Directed bench for row_scan_reader: inputs driven and outputs sampled on
// the falling edge, expected values written out by hand per scenario.
module tb_row_scan_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [0:7] wr_data;
  logic       scan_start;
  logic [3:0] scan_first;
  logic [3:0] scan_last;
  logic       out_valid;
  logic       out_ready;
  logic [0:7] out_data;
  logic [3:0] out_addr;
  logic       out_last;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  row_scan_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .scan_start (scan_start),
    .scan_first (scan_first),
    .scan_last  (scan_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Leaves the bench at the falling edge of the first output cycle.
  task automatic start_scan(input logic [3:0] f, input logic [3:0] l);
    scan_start = 1'b1;
    scan_first = f;
    scan_last  = l;
    @(negedge clk);
    scan_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    scan_start = 1'b0; scan_first = '0; scan_last = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", out_data); end
    n_checks++; if (out_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", out_addr); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", out_last); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic fill_rows();
    for (int k = 0; k < 16; k++) begin
      wr_en = 1'b1; wr_addr = 4'(k); wr_data = 8'(8'h10 + k);
      @(negedge clk);
    end
    wr_en = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    start_scan(4'd2, 4'd5);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d] got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== 8'(8'h12 + i)) begin n_fail++; $display("FAIL basic_data[%0d] got %h want %h", i, out_data, 8'(8'h12 + i)); end
      n_checks++; if (out_addr !== 4'(2 + i)) begin n_fail++; $display("FAIL basic_addr[%0d] got %0d want %0d", i, out_addr, 2 + i); end
      n_checks++; if (out_last !== (i == 3)) begin n_fail++; $display("FAIL basic_last[%0d] got %b want %b", i, out_last, (i == 3)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy[%0d] got %b want 1", i, busy); end
      @(negedge clk);
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_after got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done got %b want 1", busy); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_addr [4];
    exp_addr[0] = 4'd14; exp_addr[1] = 4'd15; exp_addr[2] = 4'd0; exp_addr[3] = 4'd1;
    out_ready = 1'b1;
    start_scan(4'd14, 4'd1);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid[%0d] got %b want 1", i, out_valid); end
      n_checks++; if (out_addr !== exp_addr[i]) begin n_fail++; $display("FAIL wrap_addr[%0d] got %0d want %0d", i, out_addr, exp_addr[i]); end
      n_checks++; if (out_data !== {4'h1, exp_addr[i]}) begin n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, out_data, {4'h1, exp_addr[i]}); end
      n_checks++; if (out_last !== (i == 3)) begin n_fail++; $display("FAIL wrap_last[%0d] got %b want %b", i, out_last, (i == 3)); end
      @(negedge clk);
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b want 1", done); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    start_scan(4'd7, 4'd7);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      n_checks++; if (out_data !== 8'h17) begin n_fail++; $display("FAIL bp_data[%0d] got %h want 17", i, out_data); end
      n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL bp_last[%0d] got %b want 1", i, out_last); end
      n_checks++; if (out_addr !== 4'd7) begin n_fail++; $display("FAIL bp_addr[%0d] got %0d want 7", i, out_addr); end
      if (i == 1) begin
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'hAA;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after got %b want 0", out_valid); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b want 1", done); end
    @(negedge clk);
    // Row 7 now holds AA from the stall-time write.
    start_scan(4'd7, 4'd7);
    n_checks++; if (out_data !== 8'hAA) begin n_fail++; $display("FAIL bp_row7_after got %h want aa", out_data); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bypass();
    out_ready = 1'b1;
    start_scan(4'd3, 4'd4);
    n_checks++; if (out_data !== 8'h13) begin n_fail++; $display("FAIL byp_row3 got %h want 13", out_data); end
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'h5C;
    @(negedge clk);
    wr_en = 1'b0;
    n_checks++; if (out_data !== 8'h5C) begin n_fail++; $display("FAIL byp_row4 got %h want 5c", out_data); end
    n_checks++; if (out_addr !== 4'd4) begin n_fail++; $display("FAIL byp_addr got %0d want 4", out_addr); end
    @(negedge clk);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL byp_done got %b want 1", done); end
    @(negedge clk);
    start_scan(4'd4, 4'd4);
    n_checks++; if (out_data !== 8'h5C) begin n_fail++; $display("FAIL byp_rescan got %h want 5c", out_data); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int n_done = 0;
    int n_valid = 0;
    out_ready = 1'b1;
    start_scan(4'd8, 4'd11);
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_data !== 8'(8'h18 + i)) begin n_fail++; $display("FAIL swb_data[%0d] got %h want %h", i, out_data, 8'(8'h18 + i)); end
      n_checks++; if (out_addr !== 4'(8 + i)) begin n_fail++; $display("FAIL swb_addr[%0d] got %0d want %0d", i, out_addr, 8 + i); end
      if (i == 1) begin
        scan_start = 1'b1; scan_first = 4'd0; scan_last = 4'd0;
      end else begin
        scan_start = 1'b0;
      end
      @(negedge clk);
    end
    scan_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done === 1'b1) n_done++;
      if (out_valid === 1'b1) n_valid++;
      @(negedge clk);
    end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL swb_done_count got %0d want 1", n_done); end
    n_checks++; if (n_valid != 0) begin n_fail++; $display("FAIL swb_extra_words got %0d want 0", n_valid); end
  endtask

  task automatic test_reset_mid_scan();
    out_ready = 1'b1;
    start_scan(4'd0, 4'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_scan(4'd0, 4'd15);
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (out_valid !== 1'b1 || out_addr !== 4'(i)) begin n_fail++; $display("FAIL rst_full_addr[%0d] got valid=%b addr=%0d want valid=1 addr=%0d", i, out_valid, out_addr, i); end
      n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_full_data[%0d] got %h want 00", i, out_data); end
      n_checks++; if (out_last !== (i == 15)) begin n_fail++; $display("FAIL rst_full_last[%0d] got %b want %b", i, out_last, (i == 15)); end
      @(negedge clk);
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rst_full_done got %b want 1", done); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    fill_rows();
    test_basic();
    test_wrap();
    test_backpressure();
    test_bypass();
    test_start_while_busy();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/row_scan_reader.md
# row_scan_reader

Read side of the 16-entry × 8-bit row array. Owns the array behind a single write port, so every storage bit has exactly one driver. A scan engine streams a contiguous, possibly wrapping range of rows to a downstream consumer over a valid/ready handshake. It sits between the row producers, which write through `wr_*`, and any block that consumes row snapshots.

## Interface
- `DEPTH`, 16: number of rows; must be 16 (address arithmetic is modulo 16).
- `WIDTH`, 8: row width; vectors are declared `[0:WIDTH-1]`, with index 0 as the MSB.
- `AW`, 4: address width; log2(DEPTH).

- `clk`  in  1  the single clock; everything samples on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  AW  row to write.
- `wr_data`  in  [0:WIDTH-1]  row data.
- `scan_start`  in  1  start request; sampled only in IDLE.
- `scan_first`  in  AW  first row of the scan; latched with `scan_start`.
- `scan_last`  in  AW  last row of the scan; latched with `scan_start`.
- `out_valid`  out  1  `out_data`, `out_addr` and `out_last` are valid.
- `out_ready`  in  1  consumer accepts the current word.
- `out_data`  out  [0:WIDTH-1]  row contents.
- `out_addr`  out  AW  row index of `out_data`.
- `out_last`  out  1  current word is the final row of the scan.
- `busy`  out  1  FSM is not in IDLE.
- `done`  out  1  one-cycle pulse after the final transfer.

## Operation
- **Storage and reset:** `mem[0:15]` is cleared to 0 by reset.
- **Writes:** when `wr_en` is high, `mem[wr_addr] <= wr_data`. Writes are accepted in every FSM state.
- **FSM states:** IDLE, SCAN, DONE.
- **IDLE → SCAN** on `scan_start`:
  - latch `first`/`last`;
  - set `ptr = first`;
  - load the output register with `mem[first]`, using the bypass rule below.
- **SCAN:**
  - `out_valid` is 1.
  - A transfer occurs when `out_valid && out_ready`.
  - On a transfer with `ptr != last`: `ptr <= ptr+1` mod 16, wrapping 15→0; the output register loads `mem[ptr+1]`.
  - On a transfer with `ptr == last`: go to DONE and drop `out_valid`.
- **DONE:** `done` is 1 for this single cycle, then the FSM returns to IDLE.
- **Scan length:** ((last − first) mod 16) + 1 words.
  - `first == last` produces 1 word.
  - `first > last` wraps, e.g. 14→1 gives rows 14, 15, 0, 1.
- **`out_last`:** equals `(ptr == last)` while `out_valid` is high, and is 0 otherwise.
- **Stability:** `out_data`, `out_addr` and `out_last` hold steady while `out_valid && !out_ready`. A write to the row currently presented does not alter `out_data`, because the output is a snapshot.
- **Write bypass:** if a write hits the row being loaded into the output register in the same cycle, the loaded value is `wr_data`. This applies both to the start load and to the post-transfer load.
- **Ignored starts:** `scan_start` in SCAN or DONE is ignored and is not queued.
- **Reset mid-scan:** the FSM goes to IDLE immediately (asynchronously) and `out_valid`, `busy` and `done` go to 0. No partial-scan state survives reset.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0, `busy`=0, `done`=0;
  - all `mem` rows = 0;
  - `ptr`, `first`, `last` = 0.
- **Start latency:** `scan_start` sampled at edge N gives `out_valid`=1 with `mem[first]` after edge N (cycle N+1).
- **Throughput:** 1 word per cycle while `out_ready` is held high. There are no bubbles between words.
- **Scan of L words with `out_ready` tied high:** `out_valid` is high for cycles N+1 … N+L, `done` pulses at cycle N+L+1, and IDLE is reached at N+L+2.
  - The earliest next accepted `scan_start` is sampled at the edge ending cycle N+L+2.
- **`busy`:** high from cycle N+1 through the DONE cycle inclusive.
- **Write-to-read visibility:** a write at edge M is visible to any output-register load at edge M via the bypass, and at all later edges.
- **Outputs:** all outputs are registered; there is no combinational path from `out_ready` to any output.

## Test plan
- **Basic scan:** reset, write row k = 8'h10+k for all k, scan first=2, last=5 with `out_ready`=1.
  - Expect `out_data` 12, 13, 14, 15 on 4 consecutive cycles, `out_addr` 2–5, and `out_last` only on row 5.
  - Expect `done` one cycle later.
- **Wrap scan:** first=14, last=1.
  - Expect rows 14, 15, 0, 1 (data 1E, 1F, 10, 11); `done` after the 4th word.
- **Backpressure:** first=last=7, `out_ready` low for 5 cycles.
  - Expect `out_valid`=1, `out_data`=17, `out_last`=1 held stable for those cycles.
  - Write `mem[7]`=AA during the stall: `out_data` stays 17.
  - Raise `out_ready`: one transfer, then `done`.
- **Bypass:** during a scan of rows 3–4, write `mem[4]`=5C in the same cycle row 3 is accepted.
  - Expect next `out_data`=5C.
  - Scan again later: row 4 reads 5C.
- **Start while busy:** pulse `scan_start` (first=0, last=0) mid-scan.
  - Expect the current scan to complete unchanged, with exactly one `done` and no second scan.
- **Reset mid-scan:** assert `rst_n`=0 during cycle 2 of a 6-word scan.
  - Expect `out_valid`, `busy` and `done` at 0 at once, with all rows reading 0 on a subsequent full scan of 0→15.
